// File: rtl/program_counter_stack_if.sv
// Control/bus bundle between the sequencer (master) and the program counter (slave).
// The sequencer drives the strobes and bits_in; the counter returns pc, bus and stack status.
interface program_counter_stack_if #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic             clr_n;
    logic             lp;
    logic             cp;
    logic             ep;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] bits_in;
    logic [WIDTH-1:0] bits_out;
    logic             bus_oe;
    logic [WIDTH-1:0] pc;
    logic             tc;
    logic [SP_W-1:0]  sp;
    logic             stk_full;
    logic             stk_empty;
    logic             stk_err;

    modport master (
        output clr_n, lp, cp, ep, call, ret, bits_in,
        input  bits_out, bus_oe, pc, tc, sp, stk_full, stk_empty, stk_err
    );

    modport slave (
        input  clr_n, lp, cp, ep, call, ret, bits_in,
        output bits_out, bus_oe, pc, tc, sp, stk_full, stk_empty, stk_err
    );
endinterface

// File: rtl/program_counter_stack.sv
// WIDTH-bit program counter with clear/load/count/bus enable; the return-address
// stack for call/ret is built only when PC_STACK_EN is defined.
module program_counter_stack #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
) (
    input logic                    clk,
    input logic                    rst,
    program_counter_stack_if.slave bus
);
    localparam int              SP_W    = $clog2(STACK_DEPTH + 1);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_RET,
        OP_CALL,
        OP_LOAD,
        OP_COUNT
    } op_e;

    op_e              op;
    logic [WIDTH-1:0] pc_p0;
    logic [WIDTH-1:0] pc_nxt;
    logic [SP_W-1:0]  sp_p0;
    logic             err_p0;
    logic             stk_full;
    logic             stk_empty;
    logic [WIDTH-1:0] top;

    // Exactly one operation per cycle; without the stack call/ret drop out of the chain.
    always_comb begin
        op = OP_HOLD;
        if (!bus.clr_n)   op = OP_CLEAR;
`ifdef PC_STACK_EN
        else if (bus.ret)  op = OP_RET;
        else if (bus.call) op = OP_CALL;
`endif
        else if (bus.lp)   op = OP_LOAD;
        else if (bus.cp)   op = OP_COUNT;
    end

    always_comb begin
        pc_nxt = pc_p0;
        case (op)
            OP_CLEAR: pc_nxt = '0;
            OP_RET:   pc_nxt = stk_empty ? pc_p0 : top;
            OP_CALL:  pc_nxt = stk_full ? pc_p0 : bus.bits_in;
            OP_LOAD:  pc_nxt = bus.bits_in;
            OP_COUNT: pc_nxt = pc_p0 + WIDTH'(1);
            default:  pc_nxt = pc_p0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_p0 <= '0;
        else     pc_p0 <= pc_nxt;
    end

`ifdef PC_STACK_EN
    logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [SP_W-1:0]  sp_nxt;
    logic             err_nxt;
    logic             push;

    assign stk_full  = (sp_p0 == SP_FULL);
    assign stk_empty = (sp_p0 == '0);

    // Entry sp-1 is the top of stack.
    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_p0 == SP_W'(i + 1)) top = stack_mem[i];
        end
    end

    always_comb begin
        sp_nxt  = sp_p0;
        err_nxt = err_p0;
        push    = 1'b0;
        case (op)
            OP_CLEAR: begin
                sp_nxt  = '0;
                err_nxt = 1'b0;
            end
            OP_RET: begin
                if (stk_empty) err_nxt = 1'b1;
                else           sp_nxt  = sp_p0 - SP_W'(1);
            end
            OP_CALL: begin
                if (stk_full) begin
                    err_nxt = 1'b1;
                end else begin
                    push   = 1'b1;
                    sp_nxt = sp_p0 + SP_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Clear leaves entries in place; they become unreachable once sp returns to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_p0  <= '0;
            err_p0 <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_mem[i] <= '0;
        end else begin
            sp_p0  <= sp_nxt;
            err_p0 <= err_nxt;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (push && sp_p0 == SP_W'(i)) stack_mem[i] <= pc_p0;
            end
        end
    end
`else
    logic unused_strobes;

    assign unused_strobes = bus.call ^ bus.ret;
    assign sp_p0          = '0;
    assign err_p0         = 1'b0;
    assign stk_full       = 1'b0;
    assign stk_empty      = 1'b1;
    assign top            = '0;
`endif

    assign bus.pc        = pc_p0;
    assign bus.sp        = sp_p0;
    assign bus.stk_err   = err_p0;
    assign bus.stk_full  = stk_full;
    assign bus.stk_empty = stk_empty;
    assign bus.bus_oe    = bus.ep;
    assign bus.bits_out  = bus.ep ? pc_p0 : '0;
    assign bus.tc        = (op == OP_COUNT) && (&pc_p0);
endmodule

// File: tb/tb_program_counter_stack.sv
// Randomised scoreboard bench for program_counter_stack with a queue-based reference model.
module tb_program_counter_stack;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SP_W  = $clog2(DEPTH + 1);
`ifdef PC_STACK_EN
    localparam bit STK_EN = 1'b1;
`else
    localparam bit STK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    program_counter_stack_if #(.WIDTH(WIDTH), .STACK_DEPTH(DEPTH)) pif ();
    program_counter_stack #(.WIDTH(WIDTH), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(pif)
    );

    typedef struct {
        int              id;
        logic [7:0]      bits_out;
        logic            bus_oe;
        logic            tc;
        logic [7:0]      pc;
        logic [SP_W-1:0] sp;
        logic            err;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_id  = 0;
    int         m_pc  = 0;
    logic [7:0] m_stk[$];
    bit         m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: pick the single winning operation, then apply it to an int PC and a queue stack.
    task automatic model_step(input bit c_n, input bit l, input bit c, input bit e,
                              input bit ca, input bit r, input logic [7:0] b, output exp_t x);
        x.id       = n_id++;
        x.bits_out = e ? 8'(m_pc) : 8'h00;
        x.bus_oe   = e;
        x.tc       = (m_pc == 255) && c && c_n && !l && !(STK_EN && (ca || r));
        if (!c_n) begin
            m_pc = 0;
            m_stk.delete();
            m_err = 1'b0;
        end else if (STK_EN && r) begin
            if (m_stk.size() > 0) m_pc = int'(m_stk.pop_back());
            else                  m_err = 1'b1;
        end else if (STK_EN && ca) begin
            if (m_stk.size() < DEPTH) begin
                m_stk.push_back(8'(m_pc));
                m_pc = int'(b);
            end else begin
                m_err = 1'b1;
            end
        end else if (l) begin
            m_pc = int'(b);
        end else if (c) begin
            m_pc = (m_pc + 1) % 256;
        end
        x.pc  = 8'(m_pc);
        x.sp  = SP_W'(m_stk.size());
        x.err = m_err;
    endtask

    task automatic drive(input bit c_n, input bit l, input bit c, input bit e,
                         input bit ca, input bit r, input logic [7:0] b);
        exp_t x;
        @(negedge clk);
        pif.clr_n   = c_n;
        pif.lp      = l;
        pif.cp      = c;
        pif.ep      = e;
        pif.call    = ca;
        pif.ret     = r;
        pif.bits_in = b;
        model_step(c_n, l, c, e, ca, r, b, x);
        sb.push_back(x);
    endtask

    // Assert rst between edges while counting with ep=1; state must drop at once.
    task automatic reset_mid();
        exp_t x;
        @(negedge clk);
        pif.clr_n = 1'b1; pif.lp = 1'b0; pif.cp = 1'b1; pif.ep = 1'b1;
        pif.call  = 1'b0; pif.ret = 1'b0; pif.bits_in = 8'h00;
        x.id       = n_id++;
        x.bits_out = 8'(m_pc);
        x.bus_oe   = 1'b1;
        x.tc       = (m_pc == 255);
        m_pc = 0;
        m_stk.delete();
        m_err = 1'b0;
        x.pc  = 8'h00;
        x.sp  = '0;
        x.err = 1'b0;
        sb.push_back(x);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid.pc", 32'(pif.pc), 32'h0);
        check("rstmid.sp", 32'(pif.sp), 32'h0);
        check("rstmid.err", 32'(pif.stk_err), 32'h0);
        check("rstmid.bits_out", 32'(pif.bits_out), 32'h0);
        check("rstmid.empty", 32'(pif.stk_empty), 32'h1);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t       x;
        logic [7:0] cap_bo;
        logic       cap_oe;
        logic       cap_tc;
        forever begin
            @(negedge clk);
            #1;
            cap_bo = pif.bits_out;
            cap_oe = pif.bus_oe;
            cap_tc = pif.tc;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check($sformatf("c%0d.bits_out", x.id), 32'(cap_bo), 32'(x.bits_out));
                check($sformatf("c%0d.bus_oe", x.id), 32'(cap_oe), 32'(x.bus_oe));
                check($sformatf("c%0d.tc", x.id), 32'(cap_tc), 32'(x.tc));
                check($sformatf("c%0d.pc", x.id), 32'(pif.pc), 32'(x.pc));
                check($sformatf("c%0d.sp", x.id), 32'(pif.sp), 32'(x.sp));
                check($sformatf("c%0d.err", x.id), 32'(pif.stk_err), 32'(x.err));
                check($sformatf("c%0d.full", x.id), 32'(pif.stk_full),
                      32'(x.sp == SP_W'(DEPTH)));
                check($sformatf("c%0d.empty", x.id), 32'(pif.stk_empty), 32'(x.sp == '0));
            end
        end
    end

    initial begin : stimulus
        bit         c_n, l, c, e, ca, r;
        logic [7:0] b;
        pif.clr_n = 1'b1; pif.lp = 1'b0; pif.cp = 1'b0; pif.ep = 1'b1;
        pif.call  = 1'b0; pif.ret = 1'b0; pif.bits_in = 8'h00;
        #1;
        check("rst.pc", 32'(pif.pc), 32'h0);
        check("rst.sp", 32'(pif.sp), 32'h0);
        check("rst.err", 32'(pif.stk_err), 32'h0);
        check("rst.empty", 32'(pif.stk_empty), 32'h1);
        check("rst.full", 32'(pif.stk_full), 32'h0);
        check("rst.bits_out", 32'(pif.bits_out), 32'h0);
        #2;
        rst = 1'b0;

        drive(1, 1, 0, 0, 0, 0, 8'h35);
        drive(1, 0, 1, 0, 0, 0, 8'h00);
        drive(1, 0, 1, 0, 0, 0, 8'h00);
        reset_mid();

        drive(1, 1, 0, 1, 0, 0, 8'hFE);
        repeat (3) drive(1, 0, 1, 1, 0, 0, 8'h00);
        drive(1, 0, 0, 1, 0, 0, 8'h00);

        drive(1, 1, 1, 1, 0, 0, 8'hA5);
        drive(1, 0, 0, 0, 0, 0, 8'h00);

        drive(1, 1, 0, 1, 0, 0, 8'h10);
        drive(1, 0, 0, 1, 1, 0, 8'h40);
        drive(1, 0, 0, 1, 1, 0, 8'h80);
        drive(1, 0, 0, 1, 0, 1, 8'h00);
        drive(1, 0, 0, 1, 0, 1, 8'h00);
        drive(1, 0, 0, 1, 0, 0, 8'h00);

        drive(0, 0, 0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) drive(1, 0, 1, 1, 1, 0, 8'(8'h20 + i));
        for (int i = 0; i < 5; i++) drive(1, 1, 1, 1, 0, 1, 8'h77);
        drive(0, 1, 1, 1, 1, 1, 8'h99);
        drive(1, 0, 0, 1, 0, 0, 8'h00);

        drive(1, 0, 0, 1, 1, 0, 8'h55);
        drive(1, 0, 1, 1, 0, 0, 8'h00);

        for (int i = 0; i < 400; i++) begin
            c_n = ($urandom_range(0, 15) != 0);
            l   = ($urandom_range(0, 5) == 0);
            c   = ($urandom_range(0, 1) == 0);
            e   = ($urandom_range(0, 1) == 0);
            ca  = ($urandom_range(0, 4) == 0);
            r   = ($urandom_range(0, 4) == 0);
            b   = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
            drive(c_n, l, c, e, ca, r, b);
        end
        drive(1, 0, 0, 1, 0, 0, 8'h00);

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d responses pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
